// File: rtl/ula_contention.sv
// ---------------------------------------------------------------------------
// ula_contention
//
// Purpose: ULA memory/I/O contention and frame interrupt generator for the
// 48K/128K Spectrum timing model. A private pixel/line counter pair advances
// on the 7 MHz enable. The contention window derived from it is combined with
// the current Z80 address/IORQ to produce a registered stall request for the
// clock-enable block. It also produces the registered frame interrupt.
//
// Optional feature macro: CONTENTION_128K_EN
//   defined   : accesses to C000-FFFF are contended when bank_contended is set
//   undefined : 48K behaviour, bank_contended is ignored
//
// Ports:
//   clk            in   28 MHz master clock
//   rst            in   asynchronous active-high reset
//   clk7en         in   pixel clock enable, one clk wide
//   a[15:0]        in   Z80 address bus
//   iorq_n         in   Z80 IORQ, active low
//   bank_contended in   paged upper bank is contended (128K option only)
//   CPUContention  out  registered stall request
//   int_n          out  registered frame interrupt, active low
//   hc[8:0]        out  pixel counter
//   vc[8:0]        out  line counter
// ---------------------------------------------------------------------------
module ula_contention #(
    parameter int HTOTAL      = 448,
    parameter int VTOTAL      = 312,
    parameter int CONT_HSTART = 0,
    parameter int INT_LINE    = 248,
    parameter int INT_LEN     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk7en,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        bank_contended,
    output logic        CPUContention,
    output logic        int_n,
    output logic [8:0]  hc,
    output logic [8:0]  vc
);

    localparam logic [8:0] H_LAST     = 9'(HTOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(VTOTAL - 1);
    localparam logic [9:0] CONT_START = 10'(CONT_HSTART);
    localparam logic [8:0] INT_LINE_L = 9'(INT_LINE);
    localparam logic [8:0] INT_LEN_L  = 9'(INT_LEN);

    logic [8:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic       cont_q, cont_d;
    logic       int_n_q, int_n_d;

    logic [9:0] hrel;
    logic       win;
    logic       acc;
    logic       unused_bits;

    // Pixel/line counters: hold without clk7en, wrap at line and frame end.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (clk7en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? 9'd0 : vc_q + 9'd1;
            end else begin
                hc_d = hc_q + 9'd1;
            end
        end
    end

    // Offset into the contention window. The extra top bit catches the
    // borrow when hc is left of the window start, so the window never wraps
    // across the end of the line; bit 8 set means offset >= 256.
    assign hrel = {1'b0, hc_q} - CONT_START;

    // Twelve contended pixel clocks out of every sixteen gives the
    // 6,5,4,3,2,1,0,0 T-state delay pattern.
    assign win = (vc_q < 9'd192) && (hrel[9:8] == 2'b00) && (hrel[3:0] < 4'd12);

    // Address-bus decode only: the real ULA contends without MREQ.
`ifdef CONTENTION_128K_EN
    assign acc = (a[15:14] == 2'b01) ||
                 (!iorq_n && !a[0]) ||
                 ((a[15:14] == 2'b11) && bank_contended);
    assign unused_bits = ^{a[13:1], hrel[7:4]};
`else
    assign acc = (a[15:14] == 2'b01) || (!iorq_n && !a[0]);
    assign unused_bits = ^{a[13:1], hrel[7:4], bank_contended};
`endif

    // Outputs are computed from the counter values present in this cycle, so
    // they trail a counter step by exactly one clk and never hold a stale stall.
    assign cont_d  = win && acc;
    assign int_n_d = !((vc_q == INT_LINE_L) && (hc_q < INT_LEN_L));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            cont_q  <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            cont_q  <= cont_d;
            int_n_q <= int_n_d;
        end
    end

    assign CPUContention = cont_q;
    assign int_n         = int_n_q;
    assign hc            = hc_q;
    assign vc            = vc_q;

endmodule

// File: tb/tb_ula_contention.sv
// ---------------------------------------------------------------------------
// tb_ula_contention
//
// Scoreboard bench for ula_contention. A reduced frame geometry (260 pixel
// clocks, 194 lines, INT on line 1) keeps two full interrupt periods and the
// border line within a short run while still covering hc >= 256.
// The reference derives hc/vc from the number of clk7en pulses since reset
// and evaluates the window/access rules directly with integer arithmetic.
// ---------------------------------------------------------------------------
module tb_ula_contention;

    localparam int HT   = 260;
    localparam int VT   = 194;
    localparam int CHS  = 0;
    localparam int IL   = 1;
    localparam int ILEN = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk7en = 1'b0;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1;
    logic        bank_contended = 1'b0;
    logic        CPUContention;
    logic        int_n;
    logic [8:0]  hc;
    logic [8:0]  vc;

    ula_contention #(
        .HTOTAL      (HT),
        .VTOTAL      (VT),
        .CONT_HSTART (CHS),
        .INT_LINE    (IL),
        .INT_LEN     (ILEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk7en         (clk7en),
        .a              (a),
        .iorq_n         (iorq_n),
        .bank_contended (bank_contended),
        .CPUContention  (CPUContention),
        .int_n          (int_n),
        .hc             (hc),
        .vc             (vc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cont;
        logic intn;
        int   hc;
        int   vc;
        int   pre;   // pulse count before the edge this entry describes
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pcount = 0;
    int   int_falls = 0;
    int   int_rises = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_win(input int h, input int v);
        int off;
        off = h - CHS;
        return (v < 192) && (off >= 0) && (off < 256) && ((off % 16) < 12);
    endfunction

    // Reference model: push the expected post-edge outputs at every edge.
    always @(posedge clk) begin
        exp_t e;
        int   h;
        int   v;
        bit   acc;
        if (rst) begin
            pcount = 0;
            e = '{1'b0, 1'b1, 0, 0, 0};
        end else begin
            h   = pcount % HT;
            v   = (pcount / HT) % VT;
            acc = (a[15:14] == 2'b01) || (!iorq_n && !a[0]);
`ifdef CONTENTION_128K_EN
            acc = acc || ((a[15:14] == 2'b11) && bank_contended);
`endif
            e.cont = ref_win(h, v) && acc;
            e.intn = !((v == IL) && (h < ILEN));
            e.pre  = pcount;
            if (clk7en) pcount++;
            e.hc = pcount % HT;
            e.vc = (pcount / HT) % VT;
        end
        sb.push_back(e);
    end

    // Monitor: pop and compare after every edge, and time the interrupt.
    logic prev_int = 1'b1;
    bit   have_fall = 1'b0;
    int   last_fall = 0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
        end else begin
            e = sb.pop_front();
            chk("CPUContention", int'(CPUContention), int'(e.cont));
            chk("int_n", int'(int_n), int'(e.intn));
            chk("hc", int'(hc), e.hc);
            chk("vc", int'(vc), e.vc);
            if (rst) begin
                have_fall = 1'b0;
            end else begin
                if (prev_int && !int_n) begin
                    int_falls++;
                    if (have_fall) chk("frame_len", e.pre - last_fall, HT * VT);
                    last_fall = e.pre;
                    have_fall = 1'b1;
                end
                if (!prev_int && int_n && have_fall) begin
                    int_rises++;
                    chk("int_width", e.pre - last_fall, ILEN);
                end
            end
            prev_int = int_n;
        end
    end

    // One stimulus cycle: drive on the falling edge, return just after the
    // following rising edge so pcount already reflects this cycle.
    task automatic step(input bit en);
        int sel;
        @(negedge clk);
        sel = int'($urandom_range(0, 5));
        case (sel)
            0: a = 16'h4000;
            1: a = 16'h8000;
            2: a = 16'hC000;
            3: a = 16'h00FE;
            4: a = 16'h00FF;
            default: a = 16'($urandom);
        endcase
        iorq_n         = ($urandom_range(0, 2) != 0);
        bank_contended = 1'($urandom);
        clk7en         = en;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hc", int'(hc), 0);
        chk("rst_vc", int'(vc), 0);
        chk("rst_cont", int'(CPUContention), 0);
        chk("rst_int_n", int'(int_n), 1);
        @(negedge clk);
        rst = 1'b0;

        // Exactly one line of pulses moves to the start of line 1.
        for (int i = 0; i < 4 * HT && pcount < HT; i++) step($urandom_range(0, 3) != 0);
        step(1'b0);
        chk("line1_hc", int'(hc), 0);
        chk("line1_vc", int'(vc), 1);

        // Random traffic through a full frame and into the next interrupt.
        for (int i = 0; i < 70000 && int_rises < 2; i++) step($urandom_range(0, 15) != 0);
        chk("int_rises_frame", int_rises, 2);

        // Asynchronous reset asserted between clock edges.
        for (int i = 0; i < 37; i++) step(1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_hc", int'(hc), 0);
        chk("async_vc", int'(vc), 0);
        chk("async_cont", int'(CPUContention), 0);
        chk("async_int_n", int'(int_n), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Counting resumes; the interrupt comes around again on line 1.
        for (int i = 0; i < 3000 && int_rises < 3; i++) step($urandom_range(0, 15) != 0);
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("int_falls_total", int_falls, 3);
        chk("int_rises_total", int_rises, 3);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
